// File: rtl/branch_tracker.sv
// In-order tracker of predicted branches between fetch and execute; checks each
// resolution against the oldest prediction and redirects fetch on a mispredict.
module branch_tracker #(
  parameter int WordSize      = 32,
  parameter int Depth         = 4,
  parameter int RecoverCycles = 2,
  parameter int CntWidth      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WordSize-1:0]        enq_pc,
  input  logic [WordSize-1:0]        enq_target,
  input  logic                       enq_taken,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       flush,
  output logic [WordSize-1:0]        npc,
  output logic [$clog2(Depth):0]     occupancy,
  output logic                       res_err,
  output logic [CntWidth-1:0]        mispredict_cnt
);

  localparam int PtrW = $clog2(Depth);
  localparam int RcW  = $clog2(RecoverCycles + 1);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  typedef enum logic {NORMAL, RECOVER} state_t;

  state_t               state;
  logic [PtrW-1:0]      head;
  logic [PtrW-1:0]      tail;
  logic [RcW-1:0]       rec_cnt;

  logic [WordSize-1:0]  pc_q     [Depth];
  logic [WordSize-1:0]  tgt_q    [Depth];
  logic                 taken_q  [Depth];

  logic                 enq_fire;
  logic                 res_fire;
  logic                 mismatch;
  logic                 pop;
  logic [WordSize-1:0]  redirect;

  // Ready depends only on registered state; the rst term keeps it low through reset.
  assign enq_ready = !rst && (state == NORMAL) && (occupancy != FullCnt);

  // NOTE: every signal gets a default before any condition, so no latch is inferred.
  always_comb begin
    enq_fire = enq_valid && enq_ready;
    res_fire = (state == NORMAL) && res_valid && (occupancy != '0);
    mismatch = res_fire && (res_taken != taken_q[head]);
    pop      = res_fire && !mismatch;
    // Actual next PC; on a correct prediction this equals the predicted one.
    redirect = res_taken ? tgt_q[head] : pc_q[head] + WordSize'(4);
  end

  // NOTE: the entry storage has no reset; head/tail/occupancy decide which slots are live.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_q[tail]    <= enq_pc;
      tgt_q[tail]   <= enq_target;
      taken_q[tail] <= enq_taken;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= NORMAL;
      head           <= '0;
      tail           <= '0;
      occupancy      <= '0;
      rec_cnt        <= '0;
      flush          <= 1'b0;
      npc            <= '0;
      res_err        <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      flush   <= mismatch;
      res_err <= (state == NORMAL) && res_valid && (occupancy == '0);
      if (res_fire) npc <= redirect;

      if (mismatch) begin
        // Everything younger than the mispredicted branch is wrong-path, including a same-cycle enqueue.
        head      <= '0;
        tail      <= '0;
        occupancy <= '0;
        state     <= RECOVER;
        rec_cnt   <= RcW'(RecoverCycles);
        if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + CntWidth'(1);
      end else begin
        if (enq_fire) tail <= tail + PtrW'(1);
        if (pop)      head <= head + PtrW'(1);
        if (enq_fire && !pop)      occupancy <= occupancy + (PtrW + 1)'(1);
        else if (pop && !enq_fire) occupancy <= occupancy - (PtrW + 1)'(1);

        if (state == RECOVER) begin
          if (rec_cnt <= RcW'(1)) begin
            state   <= NORMAL;
            rec_cnt <= '0;
          end else begin
            rec_cnt <= rec_cnt - RcW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_tracker.sv
// Directed bench for branch_tracker: hand-computed expectations per scenario.
module tb_branch_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_target;
  logic        enq_taken;
  logic        res_valid;
  logic        res_taken;
  logic        flush;
  logic [31:0] npc;
  logic [2:0]  occupancy;
  logic        res_err;
  logic [15:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  branch_tracker dut (
    .clk            (clk),
    .rst            (rst),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_pc         (enq_pc),
    .enq_target     (enq_target),
    .enq_taken      (enq_taken),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .flush          (flush),
    .npc            (npc),
    .occupancy      (occupancy),
    .res_err        (res_err),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    enq_valid  = 1'b1;
    enq_pc     = pc;
    enq_target = tgt;
    enq_taken  = tk;
    tick();
    enq_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_pre got %0b exp 0", enq_ready); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b exp 0", flush); end
    checks++; if (npc !== 32'h0) begin errors++; $display("FAIL reset_npc got %0h exp 0", npc); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err got %0b exp 0", res_err); end
    checks++; if (mispredict_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", mispredict_cnt); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_during got %0b exp 0", enq_ready); end
    rst = 1'b0;
    #1;
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %0b exp 1", enq_ready); end
  endtask

  task automatic test_match();
    enq(32'h100, 32'h200, 1'b1);
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL match_occ1 got %0d exp 1", occupancy); end
    res_valid = 1'b1;
    res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL match_flush got %0b exp 0", flush); end
    checks++; if (npc !== 32'h200) begin errors++; $display("FAIL match_npc got %0h exp 200", npc); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL match_occ0 got %0d exp 0", occupancy); end
  endtask

  task automatic test_full();
    logic [31:0] exp_npc [4] = '{32'h14, 32'h24, 32'h34, 32'h44};
    logic [2:0]  exp_occ [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 4; i++) enq(32'h10 * (i + 1), 32'h900, 1'b0);
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ got %0d exp 4", occupancy); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", enq_ready); end
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1;
      res_taken = 1'b0;
      // At full, a simultaneous enqueue must be refused.
      enq_valid  = (i == 0);
      enq_pc     = 32'h50;
      enq_target = 32'h950;
      enq_taken  = 1'b0;
      tick();
      res_valid = 1'b0;
      enq_valid = 1'b0;
      checks++; if (npc !== exp_npc[i]) begin errors++; $display("FAIL full_npc%0d got %0h exp %0h", i, npc, exp_npc[i]); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL full_flush%0d got %0b exp 0", i, flush); end
      checks++; if (occupancy !== exp_occ[i]) begin errors++; $display("FAIL full_occ%0d got %0d exp %0d", i, occupancy, exp_occ[i]); end
    end
  endtask

  task automatic test_mispredict();
    enq(32'h1000, 32'h3000, 1'b0);
    enq(32'h2000, 32'h4000, 1'b1);
    enq(32'h5000, 32'h6000, 1'b0);
    res_valid  = 1'b1;
    res_taken  = 1'b1;
    enq_valid  = 1'b1;
    enq_pc     = 32'h7000;
    enq_target = 32'h7100;
    enq_taken  = 1'b0;
    tick();
    res_valid = 1'b0;
    enq_valid = 1'b0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush got %0b exp 1", flush); end
    checks++; if (npc !== 32'h3000) begin errors++; $display("FAIL mis_npc got %0h exp 3000", npc); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mis_occ got %0d exp 0", occupancy); end
    checks++; if (mispredict_cnt !== 16'd1) begin errors++; $display("FAIL mis_cnt got %0d exp 1", mispredict_cnt); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL mis_ready0 got %0b exp 0", enq_ready); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mis_flush_pulse got %0b exp 0", flush); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL mis_ready1 got %0b exp 0", enq_ready); end
    tick();
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL mis_ready2 got %0b exp 1", enq_ready); end
    checks++; if (npc !== 32'h3000) begin errors++; $display("FAIL mis_npc_hold got %0h exp 3000", npc); end
  endtask

  task automatic test_wrap_and_recover_ignore();
    enq(32'hFFFF_FFFC, 32'h8000, 1'b1);
    res_valid = 1'b1;
    res_taken = 1'b0;
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL wrap_flush got %0b exp 1", flush); end
    checks++; if (npc !== 32'h0) begin errors++; $display("FAIL wrap_npc got %0h exp 0", npc); end
    checks++; if (mispredict_cnt !== 16'd2) begin errors++; $display("FAIL wrap_cnt got %0d exp 2", mispredict_cnt); end
    // res_valid stays high into RECOVER with an empty queue: must be ignored.
    res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL rec_res_err got %0b exp 0", res_err); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rec_flush got %0b exp 0", flush); end
    checks++; if (mispredict_cnt !== 16'd2) begin errors++; $display("FAIL rec_cnt got %0d exp 2", mispredict_cnt); end
    tick();
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL rec_ready got %0b exp 1", enq_ready); end
  endtask

  task automatic test_empty_res();
    res_valid = 1'b1;
    res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL empty_res_err got %0b exp 1", res_err); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL empty_flush got %0b exp 0", flush); end
    checks++; if (mispredict_cnt !== 16'd2) begin errors++; $display("FAIL empty_cnt got %0d exp 2", mispredict_cnt); end
    checks++; if (npc !== 32'h0) begin errors++; $display("FAIL empty_npc got %0h exp 0", npc); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL empty_occ got %0d exp 0", occupancy); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL empty_ready got %0b exp 1", enq_ready); end
    tick();
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL empty_pulse got %0b exp 0", res_err); end
  endtask

  task automatic test_reset_priority();
    // Reset on the same edge as a mispredict with two entries pending.
    enq(32'hA0, 32'hB0, 1'b0);
    enq(32'hC0, 32'hD0, 1'b0);
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL rstp_occ_pre got %0d exp 2", occupancy); end
    res_valid = 1'b1;
    res_taken = 1'b1;
    rst       = 1'b1;
    tick();
    res_valid = 1'b0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rstp_occ got %0d exp 0", occupancy); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstp_flush got %0b exp 0", flush); end
    checks++; if (mispredict_cnt !== 16'd0) begin errors++; $display("FAIL rstp_cnt got %0d exp 0", mispredict_cnt); end
    checks++; if (npc !== 32'h0) begin errors++; $display("FAIL rstp_npc got %0h exp 0", npc); end
    rst = 1'b0;
    #1;
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL rstp_ready got %0b exp 1", enq_ready); end
    // Reset during RECOVER, in the flush cycle.
    enq(32'h300, 32'h400, 1'b1);
    res_valid = 1'b1;
    res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rstr_flush_pre got %0b exp 1", flush); end
    rst = 1'b1;
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstr_flush got %0b exp 0", flush); end
    checks++; if (mispredict_cnt !== 16'd0) begin errors++; $display("FAIL rstr_cnt got %0d exp 0", mispredict_cnt); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rstr_occ got %0d exp 0", occupancy); end
    rst = 1'b0;
    #1;
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL rstr_ready got %0b exp 1", enq_ready); end
  endtask

  task automatic test_back_to_back();
    // Match with a concurrent enqueue keeps occupancy constant.
    enq(32'h600, 32'h700, 1'b1);
    res_valid  = 1'b1;
    res_taken  = 1'b1;
    enq_valid  = 1'b1;
    enq_pc     = 32'h800;
    enq_target = 32'h880;
    enq_taken  = 1'b0;
    tick();
    res_taken = 1'b0;
    enq_valid = 1'b0;
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL b2b_occ got %0d exp 1", occupancy); end
    checks++; if (npc !== 32'h700) begin errors++; $display("FAIL b2b_npc0 got %0h exp 700", npc); end
    tick();
    res_valid = 1'b0;
    checks++; if (npc !== 32'h804) begin errors++; $display("FAIL b2b_npc1 got %0h exp 804", npc); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL b2b_occ0 got %0d exp 0", occupancy); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_flush got %0b exp 0", flush); end
  endtask

  initial begin
    rst        = 1'b1;
    enq_valid  = 1'b0;
    enq_pc     = '0;
    enq_target = '0;
    enq_taken  = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    test_reset();
    test_match();
    test_full();
    test_mispredict();
    test_wrap_and_recover_ignore();
    test_empty_res();
    test_back_to_back();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
